mem_wb_writeback_regfile: RTL and testbench

- Consumer end of the 72-bit MEM/WB pipeline bundle.
- Unpacks the bundle and selects the write-back value: load data or ALU result.
- Commits that value into a 32x32 architectural register file and serves the two decode-stage read ports.
- Counts retired instructions.
- Sits between the MEM/WB pipeline register and the ID stage of the RISC-V core.

---
 rtl/mem_wb_writeback_regfile.sv | 80 ++++++++
 tb/tb_mem_wb_writeback_regfile.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback_regfile.sv
// MEM/WB consumer: unpacks the write-back bundle, selects load data or ALU result,
// commits it into the 32x32 architectural register file and counts retired instructions.
module mem_wb_writeback_regfile #(
  parameter logic [31:0] SP_INIT   = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_INIT   = 32'h1000_8000,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid_i,
  input  logic        reg_write_i,
  input  logic [71:0] mem_wb_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] instret_o
);

  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [4:0]  rd;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic        unused_mem_read;

  logic [31:0] regs [32];
  logic [31:0] instret_q;

  assign mem_read   = mem_wb_i[71];
  assign mem_write  = mem_wb_i[70];
  assign mem_to_reg = mem_wb_i[69];
  assign rd         = mem_wb_i[68:64];
  assign read_data  = mem_wb_i[63:32];
  assign alu_result = mem_wb_i[31:0];

  // MemRead only matters upstream; the write-back choice is MemToReg alone.
  assign unused_mem_read = mem_read;

  // A store that also claims reg_write is treated as a plain store.
  assign wb_data_o = mem_to_reg ? read_data : alu_result;
  assign wb_rd_o   = rd;
  assign wb_we_o   = wb_valid_i & reg_write_i & ~mem_write & (rd != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 2)      regs[i] <= SP_INIT;
        else if (i == 3) regs[i] <= GP_INIT;
        else             regs[i] <= '0;
      end
    end else if (wb_we_o) begin
      regs[rd] <= wb_data_o;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) instret_q <= '0;
    else if (wb_valid_i) instret_q <= instret_q + 32'd1;
  end

  assign instret_o = instret_q;

  // Bypass lets decode see a write that commits on the coming posedge.
  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] val;
    val = regs[addr];
    if (addr == 5'd0) val = '0;
    else if (BYPASS_EN && wb_we_o && (addr == rd)) val = wb_data_o;
    return val;
  endfunction

  assign rs1_data_o = read_port(rs1_addr_i);
  assign rs2_data_o = read_port(rs2_addr_i);

endmodule

// File: tb/tb_mem_wb_writeback_regfile.sv
// Bench for mem_wb_writeback_regfile: directed test-plan steps followed by random
// bundles, checked against an architectural register-file model.
module tb_mem_wb_writeback_regfile;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic        reg_write;
  logic [71:0] mem_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;

  logic [31:0] rs1_b, rs2_b, wbd_b, ins_b;
  logic        we_b;
  logic [4:0]  rd_b;
  logic [31:0] rs1_n, rs2_n, wbd_n, ins_n;
  logic        we_n;
  logic [4:0]  rd_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [32];
  logic [31:0] mcount;
  logic        exp_we;
  logic [31:0] exp_data;
  logic [4:0]  cur_rd;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  mem_wb_writeback_regfile #(.BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .wb_valid_i(wb_valid), .reg_write_i(reg_write),
    .mem_wb_i(mem_wb), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_b), .rs2_data_o(rs2_b), .wb_we_o(we_b), .wb_rd_o(rd_b),
    .wb_data_o(wbd_b), .instret_o(ins_b)
  );

  mem_wb_writeback_regfile #(.BYPASS_EN(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wb_valid_i(wb_valid), .reg_write_i(reg_write),
    .mem_wb_i(mem_wb), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_n), .rs2_data_o(rs2_n), .wb_we_o(we_n), .wb_rd_o(rd_n),
    .wb_data_o(wbd_n), .instret_o(ins_n)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[2] = SP;
    mdl[3] = GP;
    mcount = '0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return '0;
    if (byp && exp_we && a == cur_rd) return exp_data;
    return mdl[a];
  endfunction

  task automatic check_all(input string ph);
    check({ph, "_wb_we"},    {31'd0, we_b},  {31'd0, exp_we});
    check({ph, "_wb_we_nb"}, {31'd0, we_n},  {31'd0, exp_we});
    check({ph, "_wb_rd"},    {27'd0, rd_b},  {27'd0, cur_rd});
    check({ph, "_wb_data"},  wbd_b, exp_data);
    check({ph, "_rs1"},      rs1_b, exp_read(rs1_addr, 1'b1));
    check({ph, "_rs2"},      rs2_b, exp_read(rs2_addr, 1'b1));
    check({ph, "_rs1_nb"},   rs1_n, exp_read(rs1_addr, 1'b0));
    check({ph, "_rs2_nb"},   rs2_n, exp_read(rs2_addr, 1'b0));
    check({ph, "_instret"},  ins_b, mcount);
    check({ph, "_instret_nb"}, ins_n, mcount);
  endtask

  // Driver: bundle launched after negedge, checked before and after the commit edge
  task automatic cycle(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic mtr, input logic [4:0] rd, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    #1;
    wb_valid  = v;
    reg_write = rw;
    mem_wb    = {mr, mw, mtr, rd, rdata, alu};
    rs1_addr  = a1;
    rs2_addr  = a2;
    exp_we    = v & rw & ~mw & (rd != 5'd0);
    exp_data  = mtr ? rdata : alu;
    cur_rd    = rd;
    #2;
    check_all("pre");
    @(posedge clk);
    if (exp_we) mdl[rd] = exp_data;
    if (v) mcount = mcount + 32'd1;
    #1;
    check_all("post");
  endtask

  task automatic peek(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  logic [31:0] snap;

  initial begin
    reset = 1'b0;
    wb_valid = 1'b0;
    reg_write = 1'b0;
    mem_wb = '0;
    rs1_addr = 5'd2;
    rs2_addr = 5'd3;
    exp_we = 1'b0;
    exp_data = '0;
    cur_rd = '0;
    model_reset();

    // Reset values with clock running
    repeat (2) @(posedge clk);
    #1;
    check("rst_x2", rs1_b, SP);
    check("rst_x3", rs2_b, GP);
    check("rst_instret", ins_b, 32'd0);
    peek(5'd5, 5'd0);
    check("rst_x5", rs1_b, 32'd0);
    check("rst_x0", rs2_b, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ALU write-back
    cycle(1, 1, 0, 0, 0, 5'd5, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 5'd5);
    check("alu_x5", rs1_b, 32'hDEAD_BEEF);
    check("alu_instret", ins_b, 32'd1);

    // Load write-back, bypass on vs off before the edge
    @(negedge clk);
    #1;
    wb_valid = 1; reg_write = 1;
    mem_wb = {1'b1, 1'b0, 1'b1, 5'd7, 32'hCAFE_0001, 32'h0000_0777};
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #2;
    check("ld_byp_pre", rs2_b, 32'hCAFE_0001);
    check("ld_nobyp_pre", rs2_n, 32'd0);
    check("ld_same_port", rs1_b, rs2_b);
    @(posedge clk);
    mdl[7] = 32'hCAFE_0001;
    mcount = mcount + 32'd1;
    #1;
    check("ld_byp_post", rs2_b, 32'hCAFE_0001);
    check("ld_nobyp_post", rs2_n, 32'hCAFE_0001);

    // MemRead without MemToReg writes the ALU result
    cycle(1, 1, 1, 0, 0, 5'd8, 32'h5555_5555, 32'h0000_0088, 5'd8, 5'd7);
    check("mr_no_mtr", rs1_b, 32'h0000_0088);

    // x0 and store suppression
    cycle(1, 1, 0, 0, 0, 5'd9, 32'd0, 32'h0000_0099, 5'd9, 5'd0);
    snap = ins_b;
    cycle(1, 1, 0, 0, 0, 5'd0, 32'd0, 32'hFFFF_FFFF, 5'd0, 5'd9);
    check("x0_we", {31'd0, we_b}, 32'd0);
    check("x0_read", rs1_b, 32'd0);
    cycle(1, 1, 0, 1, 0, 5'd9, 32'd0, 32'h1111_2222, 5'd9, 5'd0);
    check("st_we", {31'd0, we_b}, 32'd0);
    check("st_x9", rs1_b, 32'h0000_0099);
    check("st_instret", ins_b, snap + 32'd2);

    // Bubbles with junk bundles
    snap = ins_b;
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 0, 0, $urandom_range(0, 1), 5'($urandom_range(1, 31)),
            $urandom, $urandom, 5'd5, 5'd7);
    check("bub_instret", ins_b, snap);
    peek(5'd5, 5'd7);
    check("bub_x5", rs1_b, 32'hDEAD_BEEF);
    check("bub_x7", rs2_b, 32'hCAFE_0001);

    // Counter wrap
    @(negedge clk);
    #1;
    wb_valid = 0;
    force dut.instret_q = 32'hFFFF_FFFF;
    force dut_nb.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    release dut_nb.instret_q;
    mcount = 32'hFFFF_FFFF;
    #1;
    check("wrap_pre", ins_b, 32'hFFFF_FFFF);
    cycle(1, 0, 0, 0, 0, 5'd4, 32'd0, 32'd0, 5'd4, 5'd5);
    check("wrap_post", ins_b, 32'd0);

    // Random bundles
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 5) == 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    // Mid-cycle reset drops the pending commit
    @(negedge clk);
    #1;
    wb_valid = 1; reg_write = 1;
    mem_wb = {1'b0, 1'b0, 1'b0, 5'd10, 32'd0, 32'hAAAA_0010};
    rs1_addr = 5'd2; rs2_addr = 5'd3;
    #2;
    reset = 1'b0;
    #1;
    check("mrst_x2", rs1_b, SP);
    check("mrst_x3", rs2_b, GP);
    check("mrst_instret", ins_b, 32'd0);
    @(posedge clk);
    @(negedge clk);
    wb_valid = 0; reg_write = 0;
    reset = 1'b1;
    model_reset();
    exp_we = 1'b0;
    #1;
    peek(5'd10, 5'd10);
    check("mrst_x10", rs1_b, 32'd0);
    check("mrst_x10_nb", rs2_n, 32'd0);
    check("mrst_instret2", ins_n, 32'd0);

    for (int i = 0; i < 40; i++)
      cycle($urandom_range(0, 1), 1, 0, 0, $urandom_range(0, 1), 5'($urandom_range(0, 31)),
            $urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
